ram_reader: RTL and testbench

//  Read-side companion of the RAM pattern writer: sweeps the 64-bit x 16K RAM port from address 0 to LAST_ADDR,

---
 rtl/ram_reader_pkg.sv | 33 +++
 rtl/ram_reader_pattern_check.sv | 31 +++
 rtl/ram_reader.sv | 151 +++++++++++++++
 tb/tb_ram_reader.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_reader_pkg.sv
// ram_reader_pkg
//   Shared definitions for the RAM pattern reader: FSM state encoding, lane
//   geometry and the pattern the RAM writer lays down, so this block and the
//   writer bench agree on a single definition of the expected contents.
package ram_reader_pkg;

    localparam int LANE_W = 16;
    localparam int LANES  = 4;
    localparam int WORD_W = LANE_W * LANES;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ISSUE   = 3'd1,
        S_WAIT    = 3'd2,
        S_PRESENT = 3'd3,
        S_GAP     = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    // Lane k of word A holds (4*A + k) mod 2^16. The shift is done on a
    // 16-bit value on purpose: the writer's word counter wraps at 16 bits.
    function automatic logic [WORD_W-1:0] expected_word(input logic [15:0] addr);
        logic [WORD_W-1:0] w;
        logic [15:0]       base;
        base = addr << 2;
        w    = '0;
        for (int k = 0; k < LANES; k++) begin
            w[k*LANE_W +: LANE_W] = base + 16'(k);
        end
        return w;
    endfunction

endpackage

// File: rtl/ram_reader_pattern_check.sv
// ram_pattern_check
//   Combinational compare of one RAM word against the writer pattern for its
//   address. Each 16-bit lane is compared independently; any lane difference
//   flags the whole word.
//   Ports:
//     addr      in   ADDR_W   address the word was read from
//     data      in   WORD_W   word returned by the RAM
//     mismatch  out  1        1 when any lane differs from the pattern
module ram_pattern_check
    import ram_reader_pkg::*;
#(
    parameter int ADDR_W = 14
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic [WORD_W-1:0] data,
    output logic              mismatch
);

    logic [WORD_W-1:0] exp_word;
    logic [LANES-1:0]  lane_mismatch;

    always_comb begin
        exp_word      = expected_word(16'(addr));
        lane_mismatch = '0;
        for (int k = 0; k < LANES; k++) begin
            lane_mismatch[k] = (data[k*LANE_W +: LANE_W] != exp_word[k*LANE_W +: LANE_W]);
        end
        mismatch = |lane_mismatch;
    end

endmodule

// File: rtl/ram_reader.sv
// ram_reader
//   Sweeps the RAM read port from address 0 to LAST_ADDR, one read in flight
//   at a time, checks every word against the writer pattern and streams the
//   words out on a valid/ready port.
//   Handshake: a word transfers on a rising edge where o_valid && i_ready;
//   while o_valid is high and i_ready is low, o_data and o_err_word hold and
//   no new read is issued.
//   Ports:
//     i_clk, i_rst_n   clock, asynchronous active-low reset
//     i_start          begin a sweep (honoured only in IDLE or DONE)
//     o_rden/o_address RAM read request
//     i_data           RAM read data, READ_LATENCY cycles after o_rden
//     o_valid/i_ready  output handshake; o_data, o_err_word qualified by o_valid
//     o_err_count      mismatching words this sweep (saturating)
//     o_busy/o_done    sweep in progress / sweep complete
//     o_state          current FSM state, for debug and checkers
module ram_reader
    import ram_reader_pkg::*;
#(
    parameter int ADDR_W       = 14,
    parameter int DATA_W       = 64,
    parameter int READ_LATENCY = 2,
    parameter int LAST_ADDR    = 16383,
    parameter int GAP_CYCLES   = 4
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    output logic              o_rden,
    output logic [ADDR_W-1:0] o_address,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [DATA_W-1:0] o_data,
    output logic              o_err_word,
    output logic [15:0]       o_err_count,
    output logic              o_busy,
    output logic              o_done,
    output state_t            o_state
);

    localparam logic [ADDR_W-1:0] LAST     = ADDR_W'(LAST_ADDR);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
    localparam logic [2:0]        WAIT_END = 3'(READ_LATENCY - 1);
    localparam logic [3:0]        GAP_END  = 4'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    state_t      state;
    state_t      state_nx;
    logic [2:0]  wait_cnt;
    logic [3:0]  gap_cnt;
    logic        wait_last;
    logic        gap_last;
    logic        at_last;
    logic        start_ok;
    logic        capture;
    logic        handshake;
    logic        mismatch;

    assign wait_last = (wait_cnt == WAIT_END);
    assign gap_last  = (gap_cnt == GAP_END);
    assign at_last   = (o_address == LAST);
    assign start_ok  = i_start && ((state == S_IDLE) || (state == S_DONE));
    assign capture   = (state == S_WAIT) && wait_last;
    assign handshake = (state == S_PRESENT) && i_ready;

    ram_pattern_check #(
        .ADDR_W (ADDR_W)
    ) u_check (
        .addr     (o_address),
        .data     (i_data),
        .mismatch (mismatch)
    );

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE, S_DONE: if (i_start) state_nx = S_ISSUE;
            S_ISSUE:        state_nx = S_WAIT;
            S_WAIT:         if (wait_last) state_nx = S_PRESENT;
            S_PRESENT: begin
                if (i_ready) begin
                    if (at_last)              state_nx = S_DONE;
                    else if (GAP_CYCLES == 0) state_nx = S_ISSUE;
                    else                      state_nx = S_GAP;
                end
            end
            S_GAP:          if (gap_last) state_nx = S_ISSUE;
            default:        state_nx = S_IDLE;
        endcase
    end

    // Outputs decoded from state; o_valid is high exactly in PRESENT, so a
    // read (ISSUE) can never coincide with a pending output word.
    always_comb begin
        o_rden  = (state == S_ISSUE);
        o_valid = (state == S_PRESENT);
        o_busy  = (state == S_ISSUE) || (state == S_WAIT) ||
                  (state == S_PRESENT) || (state == S_GAP);
        o_done  = (state == S_DONE);
        o_state = state;
    end

    // Latency and gap counters run only inside their state and sit at zero
    // otherwise, so each entry into WAIT/GAP starts a fresh count.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wait_cnt <= 3'd0;
            gap_cnt  <= 4'd0;
        end else begin
            wait_cnt <= (state == S_WAIT) ? wait_cnt + 3'd1 : 3'd0;
            gap_cnt  <= (state == S_GAP)  ? gap_cnt + 4'd1  : 4'd0;
        end
    end

    // Address, captured word and error counter
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_address   <= '0;
            o_data      <= '0;
            o_err_word  <= 1'b0;
            o_err_count <= 16'd0;
        end else begin
            if (start_ok) begin
                o_address   <= '0;
                o_err_count <= 16'd0;
            end
            if (capture) begin
                o_data     <= i_data;
                o_err_word <= mismatch;
                if (mismatch && (o_err_count != 16'hFFFF)) begin
                    o_err_count <= o_err_count + 16'd1;
                end
            end
            // The address stops at LAST_ADDR rather than wrapping.
            if (handshake && !at_last) begin
                o_address <= o_address + ADDR_ONE;
            end
        end
    end

endmodule

// File: tb/tb_ram_reader.sv
module tb_ram_reader;
    import ram_reader_pkg::*;

    localparam logic [63:0] POISON = 64'hBAD0_BAD0_BAD0_BAD0;
    localparam int LAST_A = 3;
    localparam int LAST_B = 16383;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_cmp = 0;
    int n_bad = 0;

    // ---------------- instance A: LAST=3, RL=2, GAP=4 ----------------
    logic        rst_n_a, start_a, rden_a, valid_a, ready_a, err_word_a, busy_a, done_a;
    logic [13:0] addr_a;
    logic [63:0] data_in_a, data_a;
    logic [15:0] err_cnt_a;
    state_t      state_a;

    ram_reader #(.ADDR_W(14), .DATA_W(64), .READ_LATENCY(2), .LAST_ADDR(LAST_A), .GAP_CYCLES(4)) u_a (
        .i_clk(clk), .i_rst_n(rst_n_a), .i_start(start_a), .o_rden(rden_a), .o_address(addr_a),
        .i_data(data_in_a), .o_valid(valid_a), .i_ready(ready_a), .o_data(data_a),
        .o_err_word(err_word_a), .o_err_count(err_cnt_a), .o_busy(busy_a), .o_done(done_a),
        .o_state(state_a)
    );

    // ---------------- instance B: LAST=16383, RL=1, GAP=0 ----------------
    logic        rst_n_b, start_b, rden_b, valid_b, ready_b, err_word_b, busy_b, done_b;
    logic [13:0] addr_b;
    logic [63:0] data_in_b, data_b;
    logic [15:0] err_cnt_b;
    state_t      state_b;

    ram_reader #(.ADDR_W(14), .DATA_W(64), .READ_LATENCY(1), .LAST_ADDR(LAST_B), .GAP_CYCLES(0)) u_b (
        .i_clk(clk), .i_rst_n(rst_n_b), .i_start(start_b), .o_rden(rden_b), .o_address(addr_b),
        .i_data(data_in_b), .o_valid(valid_b), .i_ready(ready_b), .o_data(data_b),
        .o_err_word(err_word_b), .o_err_count(err_cnt_b), .o_busy(busy_b), .o_done(done_b),
        .o_state(state_b)
    );

    // ---------------- behavioural RAMs ----------------
    logic [63:0] mem_a [0:3];
    logic [63:0] mem_b [0:16383];
    logic [63:0] pipe_a;

    // Data appears READ_LATENCY cycles after the read; any other cycle
    // returns a poison word so a mistimed capture is visible.
    always @(posedge clk) begin
        pipe_a    <= rden_a ? mem_a[addr_a[1:0]] : POISON;
        data_in_a <= pipe_a;
        data_in_b <= rden_b ? mem_b[addr_b] : POISON;
    end

    function automatic logic [63:0] pat(input int a);
        logic [63:0] w;
        for (int k = 0; k < 4; k++) w[16*k +: 16] = 16'(4 * a + k);
        return w;
    endfunction

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- scoreboards ----------------
    logic [13:0] exp_addr_a[$];
    logic [63:0] exp_q_a[$];
    logic        exp_err_a[$];
    int          rden_cyc_a[$];
    int          valid_cyc_a[$];
    int          words_a;
    logic [63:0] first_data_a;
    logic        valid_prev_a = 1'b0;

    logic [13:0] exp_addr_b[$];
    logic [63:0] exp_q_b[$];
    logic        exp_err_b[$];
    int          words_b;
    logic [63:0] last_data_b;

    always @(negedge clk) begin
        if (rst_n_a) begin
            if (rden_a && valid_a) check("rden_while_valid_a", 64'(valid_a), 64'd0);
            if (rden_a) begin
                rden_cyc_a.push_back(cyc);
                if (exp_addr_a.size() == 0) check("extra_rden_a", 64'(rden_a), 64'd0);
                else check("rden_addr_a", 64'(addr_a), 64'(exp_addr_a.pop_front()));
            end
            if (valid_a && !valid_prev_a) valid_cyc_a.push_back(cyc);
            if (valid_a && ready_a) begin
                if (exp_q_a.size() == 0) check("extra_word_a", 64'(valid_a), 64'd0);
                else begin
                    check("data_a", data_a, exp_q_a.pop_front());
                    check("err_word_a", 64'(err_word_a), 64'(exp_err_a.pop_front()));
                end
                if (words_a == 0) first_data_a = data_a;
                words_a++;
            end
        end
        valid_prev_a = valid_a;
    end

    always @(negedge clk) begin
        if (rst_n_b) begin
            if (rden_b && valid_b) check("rden_while_valid_b", 64'(valid_b), 64'd0);
            if (rden_b) begin
                if (exp_addr_b.size() == 0) check("extra_rden_b", 64'(rden_b), 64'd0);
                else check("rden_addr_b", 64'(addr_b), 64'(exp_addr_b.pop_front()));
            end
            if (valid_b && ready_b) begin
                if (exp_q_b.size() == 0) check("extra_word_b", 64'(valid_b), 64'd0);
                else begin
                    check("data_b", data_b, exp_q_b.pop_front());
                    check("err_word_b", 64'(err_word_b), 64'(exp_err_b.pop_front()));
                end
                last_data_b = data_b;
                words_b++;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic sweep_a(input bit rand_ready, input int stall_addr, input bit mid_start);
        int exp_errs = 0;
        int budget = 0;
        bit stalled = 0;
        exp_addr_a.delete(); exp_q_a.delete(); exp_err_a.delete();
        rden_cyc_a.delete(); valid_cyc_a.delete();
        words_a = 0;
        for (int a = 0; a <= LAST_A; a++) begin
            exp_addr_a.push_back(14'(a));
            exp_q_a.push_back(mem_a[a]);
            exp_err_a.push_back(mem_a[a] !== pat(a));
            if (mem_a[a] !== pat(a)) exp_errs++;
        end
        @(posedge clk); #1 start_a = 1'b1; ready_a = 1'b1;
        @(posedge clk); #1 start_a = 1'b0;
        check("start_busy_a", 64'(busy_a), 64'd1);
        check("start_done_clr_a", 64'(done_a), 64'd0);
        check("start_errcnt_clr_a", 64'(err_cnt_a), 64'd0);
        while (!done_a && budget < 2000) begin
            if (stall_addr >= 0 && !stalled && valid_a && addr_a == 14'(stall_addr)) begin
                ready_a = 1'b0;
                for (int i = 0; i < 20; i++) begin
                    @(posedge clk); #1;
                    check("stall_data_a", data_a, mem_a[stall_addr]);
                    check("stall_valid_a", 64'(valid_a), 64'd1);
                    check("stall_rden_a", 64'(rden_a), 64'd0);
                end
                stalled = 1;
            end
            ready_a = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
            start_a = mid_start && (budget == 5 || budget == 12);
            @(posedge clk); #1;
            budget++;
        end
        start_a = 1'b0;
        ready_a = 1'b1;
        check("done_a", 64'(done_a), 64'd1);
        check("busy_end_a", 64'(busy_a), 64'd0);
        check("words_a", 64'(words_a), 64'(LAST_A + 1));
        check("err_count_a", 64'(err_cnt_a), 64'(exp_errs));
        check("addr_end_a", 64'(addr_a), 64'(LAST_A));
        repeat (5) @(posedge clk);
        #1 check("done_held_a", 64'(done_a), 64'd1);
    endtask

    task automatic fill_b();
        exp_addr_b.delete(); exp_q_b.delete(); exp_err_b.delete();
        words_b = 0;
        for (int a = 0; a <= LAST_B; a++) begin
            exp_addr_b.push_back(14'(a));
            exp_q_b.push_back(mem_b[a]);
            exp_err_b.push_back(mem_b[a] !== pat(a));
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int budget;
        rst_n_a = 1'b0; rst_n_b = 1'b0;
        start_a = 1'b0; start_b = 1'b0;
        ready_a = 1'b0; ready_b = 1'b0;
        for (int a = 0; a <= LAST_A; a++) mem_a[a] = pat(a);
        for (int a = 0; a <= LAST_B; a++) mem_b[a] = pat(a);

        repeat (3) @(posedge clk);
        #1;
        check("rst_rden", 64'(rden_a), 64'd0);
        check("rst_valid", 64'(valid_a), 64'd0);
        check("rst_busy", 64'(busy_a), 64'd0);
        check("rst_done", 64'(done_a), 64'd0);
        check("rst_addr", 64'(addr_a), 64'd0);
        check("rst_data", data_a, 64'd0);
        check("rst_errcnt", 64'(err_cnt_a), 64'd0);
        rst_n_a = 1'b1; rst_n_b = 1'b1;

        // 1: clean sweep, always ready; latency and first word
        sweep_a(0, -1, 0);
        check("addr0_data", first_data_a, 64'h0003_0002_0001_0000);
        check("rden_count_a", 64'(rden_cyc_a.size()), 64'd4);
        if (rden_cyc_a.size() >= 2 && valid_cyc_a.size() >= 1) begin
            check("lat_rden_to_valid", 64'(valid_cyc_a[0] - rden_cyc_a[0]), 64'd3);
            check("lat_rden_to_rden", 64'(rden_cyc_a[1] - rden_cyc_a[0]), 64'd8);
        end

        // 2: corrupted lane, random back-pressure
        mem_a[2][31:16] = 16'hDEAD;
        sweep_a(1, -1, 0);

        // 6: restart after DONE clears the error count; start while busy ignored
        mem_a[2] = pat(2);
        sweep_a(1, -1, 1);

        // 3: long stall on word 1
        sweep_a(1, 1, 0);

        // 4: reset mid-WAIT at address 5 on the long instance
        fill_b();
        @(posedge clk); #1 start_b = 1'b1; ready_b = 1'b1;
        @(posedge clk); #1 start_b = 1'b0;
        budget = 0;
        while (!(state_b == S_WAIT && addr_b == 14'd5) && budget < 200) begin
            @(posedge clk); #1; budget++;
        end
        check("reach_wait5_b", 64'(addr_b), 64'd5);
        #2 rst_n_b = 1'b0;
        #1;
        check("abort_rden_b", 64'(rden_b), 64'd0);
        check("abort_valid_b", 64'(valid_b), 64'd0);
        check("abort_busy_b", 64'(busy_b), 64'd0);
        check("abort_done_b", 64'(done_b), 64'd0);
        check("abort_addr_b", 64'(addr_b), 64'd0);
        check("abort_data_b", data_b, 64'd0);
        check("abort_errcnt_b", 64'(err_cnt_b), 64'd0);
        @(posedge clk); #1 rst_n_b = 1'b1;

        // 5: full sweep with restart at address 0
        fill_b();
        @(posedge clk); #1 start_b = 1'b1;
        @(posedge clk); #1 start_b = 1'b0;
        check("restart_busy_b", 64'(busy_b), 64'd1);
        budget = 0;
        while (!done_b && budget < 80000) begin
            ready_b = ($urandom_range(0, 15) != 0);
            @(posedge clk); #1; budget++;
        end
        ready_b = 1'b1;
        check("done_b", 64'(done_b), 64'd1);
        check("words_b", 64'(words_b), 64'(LAST_B + 1));
        check("last_word_b", last_data_b, 64'hFFFF_FFFE_FFFD_FFFC);
        check("addr_end_b", 64'(addr_b), 64'h3FFF);
        check("err_count_b", 64'(err_cnt_b), 64'd0);
        check("left_rden_b", 64'(exp_addr_b.size()), 64'd0);
        repeat (4) @(posedge clk);
        #1 check("no_wrap_addr_b", 64'(addr_b), 64'h3FFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
